// File: rtl/muldiv_if.sv
// Handshake and operand/write-back bundle between the pipeline and muldiv_unit.
// master: pipeline side (drives start/op/operands/rd_in, observes status and write-back).
// slave : execute unit side (consumes request, drives busy/done/result/rd_out/we_out).
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we_out;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in,
        input  busy, done, result, rd_out, we_out
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in,
        output busy, done, result, rd_out, we_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit, one bit per cycle, fixed 32-cycle latency.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset
//   bus    - muldiv_if.slave: start/op/rs1_val/rs2_val/rd_in in,
//            busy/done/result/rd_out/we_out out (all registered)
// op: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned DW = 2 * XLEN;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        op_q, op_d;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [XLEN-1:0]   opnd_q, opnd_d;
    // MUL: {partial product high, multiplier shifting out}; DIV: low half is dividend->quotient.
    logic [DW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;

    // One-iteration datapath values
    logic [XLEN:0]     mul_sum;
    logic [DW-1:0]     mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;

    // Shift-add multiply step and restoring divide step
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_sub   = div_shift - {1'b0, opnd_q};
        // Remainder stays below the divisor, so the top bit is always zero here.
        rem_next  = XLEN'(div_ge ? div_sub : div_shift);
        quo_next  = {acc_q[XLEN-2:0], div_ge};
    end

    // Next-state and next-register logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        rd_lat_d = rd_lat_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    count_d  = CW'(XLEN - 1);
                    op_d     = bus.op;
                    opnd_d   = bus.op[1] ? bus.rs2_val : bus.rs1_val;
                    acc_d    = {XLEN'(0), (bus.op[1] ? bus.rs1_val : bus.rs2_val)};
                    rem_d    = '0;
                    rd_lat_d = bus.rd_in;
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    acc_d = {acc_q[DW-1:XLEN], quo_next};
                    rem_d = rem_next;
                end else begin
                    acc_d = mul_next;
                end
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d  = DONE;
                    count_d  = '0;
                    done_d   = 1'b1;
                    rd_out_d = rd_lat_q;
                    case (op_q)
                        OP_MUL:   result_d = mul_next[XLEN-1:0];
                        OP_MULHU: result_d = mul_next[DW-1:XLEN];
                        OP_DIVU:  result_d = quo_next;
                        default:  result_d = rem_next;
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        // x0 is hard-wired zero, so never request a write to it.
        we_d   = done_d && (rd_out_d != 5'd0);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            rd_lat_q <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            rd_lat_q <= rd_lat_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.we_out = we_q;

endmodule
